// File: rtl/i2s_rx_frame_ctrl.sv
// I2S receive frame sequencer: generates ws, drives the left/right receiver
// enables and reset, and pairs their samples into a single-entry stereo buffer.
module i2s_rx_frame_ctrl #(
  parameter int BITS_PRECISION = 10,
  parameter int SLOT_BITS      = 16
) (
  input  logic                      sck,
  input  logic                      rst_n,
  input  logic                      run,
  output logic                      ws,
  output logic                      rx_rst,
  output logic                      l_enable,
  output logic                      r_enable,
  input  logic [BITS_PRECISION-1:0] l_data,
  input  logic                      l_data_en,
  input  logic [BITS_PRECISION-1:0] r_data,
  input  logic                      r_data_en,
  output logic [BITS_PRECISION-1:0] out_left,
  output logic [BITS_PRECISION-1:0] out_right,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] EN_HI    = CW'(BITS_PRECISION);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t                    state_reg, state_next;
  logic [CW-1:0]             bit_cnt_reg, bit_cnt_next;
  logic                      ws_reg, rx_rst_reg, l_enable_reg, r_enable_reg;
  logic                      l_enable_next, r_enable_next, in_window;
  logic [BITS_PRECISION-1:0] pending_left_reg;
  logic                      left_captured_reg;
  logic [BITS_PRECISION-1:0] out_left_reg, out_right_reg;
  logic                      out_valid_reg, overflow_reg;
  logic                      active, deliver, accept, drop;

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg + CNT_ONE;
    case (state_reg)
      IDLE: begin
        bit_cnt_next = '0;
        if (run) state_next = LEFT;
      end
      LEFT: begin
        if (bit_cnt_reg == CNT_LAST) begin
          state_next   = RIGHT;
          bit_cnt_next = '0;
        end
      end
      RIGHT: begin
        // run is only sampled at the frame boundary so frames are never cut short
        if (bit_cnt_reg == CNT_LAST) begin
          state_next   = run ? LEFT : IDLE;
          bit_cnt_next = '0;
        end
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  // One sck of I2S data delay after the ws edge, then BITS_PRECISION bits
  assign in_window     = (bit_cnt_reg >= CNT_ONE) && (bit_cnt_reg <= EN_HI);
  assign l_enable_next = (state_reg == LEFT)  && in_window;
  assign r_enable_next = (state_reg == RIGHT) && in_window;

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      ws_reg       <= 1'b0;
      rx_rst_reg   <= 1'b1;
      l_enable_reg <= 1'b0;
      r_enable_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      ws_reg       <= (state_next == RIGHT);
      rx_rst_reg   <= (state_reg == IDLE);
      l_enable_reg <= l_enable_next;
      r_enable_reg <= r_enable_next;
    end
  end

  assign active  = (state_reg != IDLE);
  assign deliver = active && r_data_en && left_captured_reg;
  assign accept  = !out_valid_reg || out_ready;
  assign drop    = deliver && !accept;

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      pending_left_reg  <= '0;
      left_captured_reg <= 1'b0;
      out_left_reg      <= '0;
      out_right_reg     <= '0;
      out_valid_reg     <= 1'b0;
      overflow_reg      <= 1'b0;
    end else begin
      // A right word without a preceding left word is discarded silently
      if (active && r_data_en)
        left_captured_reg <= 1'b0;
      if (active && l_data_en) begin
        pending_left_reg  <= l_data;
        left_captured_reg <= 1'b1;
      end

      if (deliver && accept) begin
        out_left_reg  <= pending_left_reg;
        out_right_reg <= r_data;
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (drop)
        overflow_reg <= 1'b1;
      else if (ovf_clr)
        overflow_reg <= 1'b0;
    end
  end

  assign ws        = ws_reg;
  assign rx_rst    = rx_rst_reg;
  assign l_enable  = l_enable_reg;
  assign r_enable  = r_enable_reg;
  assign out_left  = out_left_reg;
  assign out_right = out_right_reg;
  assign out_valid = out_valid_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// Directed bench for i2s_rx_frame_ctrl: behavioural receivers answer the
// enables with data_en pulses; cycle indices below are hand-derived.
module tb_i2s_rx_frame_ctrl;
  localparam int BP = 10;

  logic          sck = 1'b0;
  logic          rst_n, run, ws, rx_rst, l_enable, r_enable;
  logic [BP-1:0] l_data, r_data, out_left, out_right;
  logic          l_data_en, r_data_en, out_valid, out_ready, overflow, ovf_clr;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            lw = 55, rw = 200;
  logic          inject_r = 1'b0;

  i2s_rx_frame_ctrl #(.BITS_PRECISION(BP), .SLOT_BITS(16)) dut (
    .sck(sck), .rst_n(rst_n), .run(run), .ws(ws), .rx_rst(rx_rst),
    .l_enable(l_enable), .r_enable(r_enable),
    .l_data(l_data), .l_data_en(l_data_en), .r_data(r_data), .r_data_en(r_data_en),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 sck = ~sck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", tag, obs, cyc);
    end
  endtask

  // Receiver model: data_en one cycle after its enable window closes
  initial begin
    logic l_prev, r_prev;
    l_prev = 1'b0; r_prev = 1'b0;
    l_data_en = 1'b0; r_data_en = 1'b0;
    l_data = '0; r_data = '0;
    forever begin
      @(posedge sck);
      #2;
      l_data_en = l_prev && !l_enable;
      r_data_en = (r_prev && !r_enable) || inject_r;
      l_data    = BP'(lw);
      r_data    = BP'(rw);
      l_prev    = l_enable;
      r_prev    = r_enable;
    end
  end

  task automatic step();
    @(negedge sck);
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    int ws_fall, ws_rise, l_rise, l_cnt, rde_idx, ov_rise, both_en, cnt;
    logic ws_p, l_p, ov_p, ovf61, ovf62;

    rst_n = 1'b0; run = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge sck);

    // 1: reset state, then a free-running frame
    check("rst_ws", ws, 0);
    check("rst_rx_rst", rx_rst, 1);
    check("rst_l_en", l_enable, 0);
    check("rst_r_en", r_enable, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_left", out_left, 0);
    check("rst_right", out_right, 0);

    rst_n = 1'b1; run = 1'b1; cyc = 0;
    ws_fall = -1; ws_rise = -1; l_rise = -1; l_cnt = 0; rde_idx = -1; ov_rise = -1;
    both_en = 0; ws_p = 1'b0; l_p = 1'b0; ov_p = 1'b0; ovf61 = 1'b0; ovf62 = 1'b0;
    while (cyc < 70) begin
      step();
      if (cyc == 31) begin lw = 7; rw = 9; end
      if (ws_p && !ws && ws_fall < 0) ws_fall = cyc;
      if (ws_fall >= 0 && !ws_p && ws && ws_rise < 0) ws_rise = cyc;
      if (ws_fall >= 0 && l_enable && !l_p && l_rise < 0) l_rise = cyc;
      if (ws_fall >= 0 && cyc < ws_fall + 16 && l_enable) l_cnt++;
      if (r_data_en && rde_idx < 0) rde_idx = cyc;
      if (out_valid && !ov_p && ov_rise < 0) ov_rise = cyc;
      if (l_enable && r_enable) both_en++;
      if (cyc == 61) ovf61 = overflow;
      if (cyc == 62) ovf62 = overflow;
      ws_p = ws; l_p = l_enable; ov_p = out_valid;
    end
    check("ws_fall_idx", ws_fall, 33);
    check("ws_half_frame", ws_rise - ws_fall, 16);
    check("l_en_delay", l_rise - ws_fall, 2);
    check("l_en_len", l_cnt, 10);
    check("valid_idx", ov_rise, 30);
    check("valid_lat", ov_rise - rde_idx, 1);
    check("both_en", both_en, 0);

    // 2: consumer stalled over two frames
    check("hold_left", out_left, 55);
    check("hold_right", out_right, 200);
    check("hold_valid", out_valid, 1);
    check("ovf_before_drop", ovf61, 0);
    check("ovf_after_drop", ovf62, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    check("clr_keeps_left", out_left, 55);

    // 3: ready coincides with a new delivery
    step_to(93);
    out_ready = 1'b1;
    step();
    check("swap_valid", out_valid, 1);
    check("swap_left", out_left, 7);
    check("swap_right", out_right, 9);
    check("swap_ovf", overflow, 0);
    step();
    check("consumed_valid", out_valid, 0);
    out_ready = 1'b0;
    lw = 11; rw = 22;

    // 4: run dropped at LEFT bit_cnt=3; frame completes then IDLE
    step_to(100);
    run = 1'b0;
    step_to(126);
    check("stop_valid", out_valid, 1);
    check("stop_left", out_left, 11);
    check("stop_right", out_right, 22);
    step_to(128);
    check("stop_ws_right", ws, 1);
    check("stop_rx_rst_lag", rx_rst, 0);
    step();
    check("idle_ws", ws, 0);
    step();
    check("idle_rx_rst", rx_rst, 1);
    cnt = 0;
    while (cyc < 139) begin
      step();
      if (l_enable || r_enable) cnt++;
    end
    check("idle_no_enables", cnt, 0);
    check("idle_ovf", overflow, 0);

    // 5: asynchronous reset at RIGHT bit_cnt=5
    run = 1'b1; out_ready = 1'b1; lw = 3; rw = 4;
    step();
    out_ready = 1'b0;
    check("restart_consumed", out_valid, 0);
    step_to(161);
    check("pre_rst_ws", ws, 1);
    check("pre_rst_r_en", r_enable, 1);
    rst_n = 1'b0; run = 1'b0;
    #1;
    check("arst_ws", ws, 0);
    check("arst_rx_rst", rx_rst, 1);
    check("arst_r_en", r_enable, 0);
    check("arst_left", out_left, 0);
    check("arst_right", out_right, 0);
    check("arst_ovf", overflow, 0);
    step_to(164);
    rst_n = 1'b1;
    cnt = 0;
    while (cyc < 200) begin
      step();
      if (out_valid) cnt++;
    end
    check("aborted_no_valid", cnt, 0);

    // 6: right-only data_en is discarded without overflow
    run = 1'b1; lw = 33; rw = 44;
    step();
    inject_r = 1'b1;
    step();
    inject_r = 1'b0;
    cnt = 0;
    while (cyc < 212) begin
      step();
      if (out_valid || overflow) cnt++;
    end
    check("right_only_ignored", cnt, 0);
    step_to(230);
    check("next_pair_valid", out_valid, 1);
    check("next_pair_left", out_left, 33);
    check("next_pair_right", out_right, 44);
    check("next_pair_ovf", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
